wb_stage_multi: RTL and testbench
=================================

Name: wb_stage_multi

Overview:
- Parametrised multi-lane write-back stage for the GenshinCPU pipeline.
- Latches LANES parallel MEM results into a flushable, stallable WB register.
- Per lane: load extension, result-select mux, final register-file write enables.
- Also resolves same-destination conflicts within a bundle and keeps a retired-instruction counter that counts each bundle exactly once across stalls.

Parameters:
LANES, 2, number of issue lanes (1..4)
DATA_W, 32, datapath and PC width
REG_AW, 5, register-file address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
wb_flush  in  1  clear WB register (priority over wb_wr)
wb_wr  in  1  load WB register from MEM inputs
wb_diswr  in  1  DCache stall: suppress RF writes and retire counting
mem_valid  in  LANES  lane carries a real instruction
mem_regwr  in  LANES  lane writes the register file
mem_pc  in  LANES*DATA_W  lane PC
mem_aluout  in  LANES*DATA_W  ALU result / load address
mem_outb  in  LANES*DATA_W  forwarded operand B (MTC0/MTHI/MTLO path)
mem_dmout  in  LANES*DATA_W  raw data-memory word
mem_loadtype  in  LANES*3  {sign, size[1:0]}: size 00=byte, 01=half, 10=word
mem_wbsel  in  LANES*2  00=PC+8, 01=ALU, 10=OutB, 11=load result
mem_dst  in  LANES*REG_AW  destination register
wb_result  out  LANES*DATA_W  selected write-back data
wb_dst  out  LANES*REG_AW  registered destination
wb_regwr  out  LANES  raw registered write enable, for forwarding logic
wb_we  out  LANES  final RF write enable
wb_pc  out  LANES*DATA_W  registered PC
wb_valid  out  LANES  registered valid
wb_retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset, asynchronous, resetn=0: all WB register fields 0, fresh flag 0, wb_retire_cnt 0. Outputs: wb_result 0 (wbsel 01, aluout 0), wb_we 0, wb_valid 0.
- Reset mid-stall discards held contents; no partial count.
- WB register update at posedge:
  - wb_flush=1: valid, regwr, fresh cleared; other fields are don't-care (cleared to 0).
  - else wb_wr=1: load all fields; fresh set to 1.
  - else: hold all fields.
- Latency: one cycle from MEM inputs to wb_* outputs. Result path is combinational from the register.
- Load extension per lane (little-endian):
  - Byte: selected by aluout[1:0].
  - Half: selected by aluout[1].
  - Word: passes dmout unchanged.
  - sign=1 sign-extends to DATA_W; sign=0 zero-extends.
  - Alignment is checked upstream; aluout[0]=1 on half is undefined.
- Result mux per lane: 00 gives pc+8 modulo 2^DATA_W (wraps); 01 aluout; 10 outb; 11 extended load.
- Final enable per lane i: wb_we[i] = valid & regwr & (dst!=0) & !wb_diswr & !conflict[i].
- Conflict: conflict[i]=1 if any lane j>i has valid, regwr and dst equal to lane i's dst. The younger, higher-index lane wins.
- Retire counter:
  - When fresh=1 and wb_diswr=0 at a posedge: add popcount(valid) to the counter and clear fresh.
  - Wraps modulo 2^CNT_W.
  - A new load in the same cycle sets fresh=1 again; the count of the outgoing bundle still applies.
  - A held bundle counts exactly once.
  - A bundle flushed before counting is never counted.
- Simultaneous flush and wr: flush wins.
- wb_diswr does not stop register loading; loading is controlled only by wb_wr.

Optional Feature:
- GENSHIN_WB_TRACE_EN defined adds ports, flattened per lane:
  - debug_wb_pc (DATA_W, equals wb_pc)
  - debug_wb_rf_wen (4 bits, {4{wb_we}})
  - debug_wb_rf_wnum (REG_AW, equals wb_dst)
  - debug_wb_rf_wdata (DATA_W, equals wb_result)
- These ports drive the golden-trace comparator; all are 0 under reset.
- Undefined: the ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then lane0 load: loadtype=3'b100 (signed byte), aluout=0x1003, dmout=0x80FF_0000, wbsel=11, regwr, dst=5, wb_wr=1 -> next cycle wb_result[0]=0xFFFF_FF80, wb_we[0]=1.
- Lane0 wbsel=00, pc=0xFFFF_FFFC -> wb_result[0]=0x0000_0004 (wrap).
- Conflict: both lanes valid+regwr with dst=7, lane0 aluout=1, lane1 aluout=2 -> wb_we=2'b10. Same bundle with dst=0 -> wb_we=2'b00.
- Stall: load a 2-valid bundle, wb_wr=0, wb_diswr=1 for 3 cycles -> wb_we=0 and wb_retire_cnt unchanged. Deassert wb_diswr -> wb_we asserts; count +2 exactly once.
- wb_flush=1 with wb_wr=1 and valid inputs -> wb_valid=0, wb_we=0, count unchanged. Then resetn pulse mid-hold -> all outputs 0 asynchronously.
- Half unsigned, aluout[1]=1, dmout=0xBEEF_1234 -> 0x0000_BEEF. Word load -> 0xBEEF_1234.

Source files
------------

// File: rtl/wb_stage_multi.sv
// wb_stage_multi: multi-lane write-back stage.
//
// Captures LANES parallel MEM results into one flushable, stallable WB register.
// For each lane it then:
//   - extends load data,
//   - selects the write-back result,
//   - qualifies the register-file write enable.
// Within a bundle, same-destination writes are resolved in favour of the
// highest-index (youngest) lane.
// A retire counter adds each bundle's valid-lane count exactly once. The
// "fresh" flag marks a loaded bundle that has not been counted yet; a DCache
// stall (wb_diswr) defers the count until the stall clears.
//
// Optional build macro GENSHIN_WB_TRACE_EN adds the flattened debug_wb_*
// ports that feed the golden-trace comparator.

module wb_stage_multi #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      wb_flush,
    input  logic                      wb_wr,
    input  logic                      wb_diswr,
    input  logic [LANES-1:0]          mem_valid,
    input  logic [LANES-1:0]          mem_regwr,
    input  logic [LANES*DATA_W-1:0]   mem_pc,
    input  logic [LANES*DATA_W-1:0]   mem_aluout,
    input  logic [LANES*DATA_W-1:0]   mem_outb,
    input  logic [LANES*DATA_W-1:0]   mem_dmout,
    input  logic [LANES*3-1:0]        mem_loadtype,
    input  logic [LANES*2-1:0]        mem_wbsel,
    input  logic [LANES*REG_AW-1:0]   mem_dst,
    output logic [LANES*DATA_W-1:0]   wb_result,
    output logic [LANES*REG_AW-1:0]   wb_dst,
    output logic [LANES-1:0]          wb_regwr,
    output logic [LANES-1:0]          wb_we,
    output logic [LANES*DATA_W-1:0]   wb_pc,
    output logic [LANES-1:0]          wb_valid,
    output logic [CNT_W-1:0]          wb_retire_cnt
`ifdef GENSHIN_WB_TRACE_EN
    ,
    output logic [LANES*DATA_W-1:0]   debug_wb_pc,
    output logic [LANES*4-1:0]        debug_wb_rf_wen,
    output logic [LANES*REG_AW-1:0]   debug_wb_rf_wnum,
    output logic [LANES*DATA_W-1:0]   debug_wb_rf_wdata
`endif
);

    // Empty-register result select is ALU (value 0), so an idle or reset lane
    // presents 0 rather than PC+8.
    localparam logic [LANES*2-1:0] SEL_IDLE = {LANES{2'b01}};

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES-1:0]        regwr_q, regwr_d;
    logic [LANES*DATA_W-1:0] pc_q, pc_d;
    logic [LANES*DATA_W-1:0] alu_q, alu_d;
    logic [LANES*DATA_W-1:0] outb_q, outb_d;
    logic [LANES*DATA_W-1:0] dm_q, dm_d;
    logic [LANES*3-1:0]      lt_q, lt_d;
    logic [LANES*2-1:0]      sel_q, sel_d;
    logic [LANES*REG_AW-1:0] dst_q, dst_d;
    logic                    fresh_q, fresh_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    count_now;

    function automatic logic [CNT_W-1:0] popcnt(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++) begin
            s = s + CNT_W'(v[k]);
        end
        return s;
    endfunction

    // Little-endian sub-word extract plus sign/zero extension.
    // Size 2'b11 is not a legal encoding and is treated like a word.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [DATA_W-1:0] dm,
        input logic [1:0]        addr_lo,
        input logic [2:0]        lt
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (addr_lo)
            2'd0:    b = dm[7:0];
            2'd1:    b = dm[15:8];
            2'd2:    b = dm[23:16];
            default: b = dm[31:24];
        endcase
        h = addr_lo[1] ? dm[31:16] : dm[15:0];
        case (lt[1:0])
            2'b00:   r = lt[2] ? {{(DATA_W-8){b[7]}}, b}   : {{(DATA_W-8){1'b0}}, b};
            2'b01:   r = lt[2] ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
            default: r = dm;
        endcase
        return r;
    endfunction

    // Next-state for the WB register, fresh flag and retire counter.
    always_comb begin
        valid_d   = valid_q;
        regwr_d   = regwr_q;
        pc_d      = pc_q;
        alu_d     = alu_q;
        outb_d    = outb_q;
        dm_d      = dm_q;
        lt_d      = lt_q;
        sel_d     = sel_q;
        dst_d     = dst_q;
        // The outgoing bundle is counted on this edge even if a new bundle
        // loads or a flush lands at the same edge.
        count_now = fresh_q & ~wb_diswr;
        cnt_d     = count_now ? cnt_q + popcnt(valid_q) : cnt_q;
        fresh_d   = count_now ? 1'b0 : fresh_q;
        if (wb_flush) begin
            valid_d = '0;
            regwr_d = '0;
            pc_d    = '0;
            alu_d   = '0;
            outb_d  = '0;
            dm_d    = '0;
            lt_d    = '0;
            sel_d   = SEL_IDLE;
            dst_d   = '0;
            fresh_d = 1'b0;
        end else if (wb_wr) begin
            valid_d = mem_valid;
            regwr_d = mem_regwr;
            pc_d    = mem_pc;
            alu_d   = mem_aluout;
            outb_d  = mem_outb;
            dm_d    = mem_dmout;
            lt_d    = mem_loadtype;
            sel_d   = mem_wbsel;
            dst_d   = mem_dst;
            fresh_d = 1'b1;
        end
    end

    // WB register, fresh flag and counter, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            regwr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            outb_q  <= '0;
            dm_q    <= '0;
            lt_q    <= '0;
            sel_q   <= SEL_IDLE;
            dst_q   <= '0;
            fresh_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            regwr_q <= regwr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            outb_q  <= outb_d;
            dm_q    <= dm_d;
            lt_q    <= lt_d;
            sel_q   <= sel_d;
            dst_q   <= dst_d;
            fresh_q <= fresh_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-lane result mux, conflict detection and final write enable.
    always_comb begin
        wb_result = '0;
        wb_we     = '0;
        for (int i = 0; i < LANES; i++) begin
            logic conflict;
            case (sel_q[i*2 +: 2])
                2'b00:   wb_result[i*DATA_W +: DATA_W] = pc_q[i*DATA_W +: DATA_W] + DATA_W'(8);
                2'b01:   wb_result[i*DATA_W +: DATA_W] = alu_q[i*DATA_W +: DATA_W];
                2'b10:   wb_result[i*DATA_W +: DATA_W] = outb_q[i*DATA_W +: DATA_W];
                default: wb_result[i*DATA_W +: DATA_W] = load_ext(dm_q[i*DATA_W +: DATA_W],
                                                                  alu_q[i*DATA_W +: 2],
                                                                  lt_q[i*3 +: 3]);
            endcase
            conflict = 1'b0;
            for (int j = 0; j < LANES; j++) begin
                if (j > i && valid_q[j] && regwr_q[j] &&
                    dst_q[j*REG_AW +: REG_AW] == dst_q[i*REG_AW +: REG_AW]) begin
                    conflict = 1'b1;
                end
            end
            wb_we[i] = valid_q[i] & regwr_q[i] & (dst_q[i*REG_AW +: REG_AW] != '0) &
                       ~wb_diswr & ~conflict;
        end
    end

    assign wb_dst        = dst_q;
    assign wb_regwr      = regwr_q;
    assign wb_pc         = pc_q;
    assign wb_valid      = valid_q;
    assign wb_retire_cnt = cnt_q;

`ifdef GENSHIN_WB_TRACE_EN
    // Trace ports mirror the committed write per lane.
    always_comb begin
        debug_wb_rf_wen = '0;
        for (int i = 0; i < LANES; i++) begin
            debug_wb_rf_wen[i*4 +: 4] = {4{wb_we[i]}};
        end
    end

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wnum  = dst_q;
    assign debug_wb_rf_wdata = wb_result;
`endif

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi (LANES=2, DATA_W=32).
module tb_wb_stage_multi;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_flush, wb_wr, wb_diswr;
    logic [1:0]  mem_valid, mem_regwr;
    logic [63:0] mem_pc, mem_aluout, mem_outb, mem_dmout;
    logic [5:0]  mem_loadtype;
    logic [3:0]  mem_wbsel;
    logic [9:0]  mem_dst;
    logic [63:0] wb_result, wb_pc;
    logic [9:0]  wb_dst;
    logic [1:0]  wb_regwr, wb_we, wb_valid;
    logic [31:0] wb_retire_cnt;
`ifdef GENSHIN_WB_TRACE_EN
    logic [63:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [7:0]  debug_wb_rf_wen;
    logic [9:0]  debug_wb_rf_wnum;
`endif

    wb_stage_multi dut (
        .clk(clk), .resetn(resetn),
        .wb_flush(wb_flush), .wb_wr(wb_wr), .wb_diswr(wb_diswr),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_pc(mem_pc),
        .mem_aluout(mem_aluout), .mem_outb(mem_outb), .mem_dmout(mem_dmout),
        .mem_loadtype(mem_loadtype), .mem_wbsel(mem_wbsel), .mem_dst(mem_dst),
        .wb_result(wb_result), .wb_dst(wb_dst), .wb_regwr(wb_regwr), .wb_we(wb_we),
        .wb_pc(wb_pc), .wb_valid(wb_valid), .wb_retire_cnt(wb_retire_cnt)
`ifdef GENSHIN_WB_TRACE_EN
        , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  regwr;
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] outb;
        logic [63:0] dm;
        logic [5:0]  lt;
        logic [3:0]  sel;
        logic [9:0]  dst;
        logic [63:0] exp_res;
        logic [1:0]  exp_we;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] r,
                                input logic [63:0] pc, input logic [63:0] alu,
                                input logic [63:0] outb, input logic [63:0] dm,
                                input logic [5:0] lt, input logic [3:0] sel,
                                input logic [9:0] dst, input logic [63:0] er,
                                input logic [1:0] ew);
        vec_t x;
        x.valid = v;   x.regwr = r;  x.pc = pc;  x.alu = alu; x.outb = outb;
        x.dm = dm;     x.lt = lt;    x.sel = sel; x.dst = dst;
        x.exp_res = er; x.exp_we = ew;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        mem_valid = x.valid; mem_regwr = x.regwr; mem_pc = x.pc;
        mem_aluout = x.alu;  mem_outb = x.outb;   mem_dmout = x.dm;
        mem_loadtype = x.lt; mem_wbsel = x.sel;   mem_dst = x.dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t stall_b;
        vecs[0] = mk(2'b01, 2'b01, 64'h0, {32'h0, 32'h1003}, 64'h0, {32'h0, 32'h80FF_0000},
                     {3'b000, 3'b100}, {2'b01, 2'b11}, {5'd0, 5'd5},
                     {32'h0, 32'hFFFF_FF80}, 2'b01);
        vecs[1] = mk(2'b11, 2'b11, {32'h0, 32'hFFFF_FFFC}, 64'h0, {32'h1234_5678, 32'h0}, 64'h0,
                     6'b0, {2'b10, 2'b00}, {5'd4, 5'd3},
                     {32'h1234_5678, 32'h0000_0004}, 2'b11);
        vecs[2] = mk(2'b11, 2'b11, 64'h0, {32'h2, 32'h1}, 64'h0, 64'h0,
                     6'b0, {2'b01, 2'b01}, {5'd7, 5'd7}, {32'h2, 32'h1}, 2'b10);
        vecs[3] = mk(2'b11, 2'b11, 64'h0, {32'h2, 32'h1}, 64'h0, 64'h0,
                     6'b0, {2'b01, 2'b01}, {5'd0, 5'd0}, {32'h2, 32'h1}, 2'b00);
        vecs[4] = mk(2'b11, 2'b11, 64'h0, {32'h0, 32'h2}, 64'h0, {32'hBEEF_1234, 32'hBEEF_1234},
                     {3'b010, 3'b001}, {2'b11, 2'b11}, {5'd9, 5'd8},
                     {32'hBEEF_1234, 32'h0000_BEEF}, 2'b11);
        vecs[5] = mk(2'b11, 2'b01, 64'h0, {32'h1, 32'h0}, 64'h0, {32'h0000_AB00, 32'h0000_8001},
                     {3'b000, 3'b101}, {2'b11, 2'b11}, {5'd11, 5'd10},
                     {32'h0000_00AB, 32'hFFFF_8001}, 2'b01);
        vecs[6] = mk(2'b01, 2'b11, 64'h0, {32'h66, 32'h55}, 64'h0, 64'h0,
                     6'b0, {2'b01, 2'b01}, {5'd6, 5'd6}, {32'h66, 32'h55}, 2'b01);
        vecs[7] = mk(2'b11, 2'b11, {32'h0040_0000, 32'h0}, {32'h0, 32'h1}, 64'h0, {32'h0, 32'h0000_7F00},
                     {3'b000, 3'b100}, {2'b00, 2'b11}, {5'd2, 5'd1},
                     {32'h0040_0008, 32'h0000_007F}, 2'b11);
        stall_b = mk(2'b11, 2'b11, 64'h0, {32'hBB, 32'hAA}, 64'h0, 64'h0,
                     6'b0, {2'b01, 2'b01}, {5'd13, 5'd12}, {32'hBB, 32'hAA}, 2'b11);

        resetn = 1'b0; wb_flush = 1'b0; wb_wr = 1'b0; wb_diswr = 1'b0;
        drive(mk(2'b0, 2'b0, 64'h0, 64'h0, 64'h0, 64'h0, 6'b0, 4'b0, 10'b0, 64'h0, 2'b0));
        #23;
        chk("reset_result", wb_result, 64'h0);
        chk("reset_we", {62'h0, wb_we}, 64'h0);
        chk("reset_valid", {62'h0, wb_valid}, 64'h0);
        chk("reset_cnt", {32'h0, wb_retire_cnt}, 64'h0);
        resetn = 1'b1;

        // Back-to-back bundles, each checked one cycle after it is loaded.
        exp_cnt = 0;
        wb_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d_result", i), wb_result, vecs[i].exp_res);
            chk($sformatf("v%0d_we", i), {62'h0, wb_we}, {62'h0, vecs[i].exp_we});
            chk($sformatf("v%0d_valid", i), {62'h0, wb_valid}, {62'h0, vecs[i].valid});
            exp_cnt += $countones(vecs[i].valid);
        end
        wb_wr = 1'b0;
        step();
        chk("table_cnt", {32'h0, wb_retire_cnt}, 64'(exp_cnt));
        step();
        chk("table_cnt_once", {32'h0, wb_retire_cnt}, 64'd14);

        // DCache stall holds the bundle without writing or counting.
        drive(stall_b);
        wb_wr = 1'b1;
        step();
        chk("stall_load_result", wb_result, stall_b.exp_res);
        wb_wr = 1'b0; wb_diswr = 1'b1;
        #1;
        chk("stall_we_off", {62'h0, wb_we}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d_cnt", i), {32'h0, wb_retire_cnt}, 64'd14);
            chk($sformatf("stall%0d_we", i), {62'h0, wb_we}, 64'h0);
        end
        wb_diswr = 1'b0;
        #1;
        chk("unstall_we", {62'h0, wb_we}, 64'h3);
        step();
        chk("unstall_cnt", {32'h0, wb_retire_cnt}, 64'd16);
        step();
        chk("unstall_cnt_once", {32'h0, wb_retire_cnt}, 64'd16);

        // Flush beats a simultaneous write; a flushed, uncounted bundle is lost.
        wb_wr = 1'b1;
        step();
        wb_diswr = 1'b1; wb_flush = 1'b1;
        step();
        wb_diswr = 1'b0; wb_flush = 1'b0; wb_wr = 1'b0;
        #1;
        chk("flush_valid", {62'h0, wb_valid}, 64'h0);
        chk("flush_we", {62'h0, wb_we}, 64'h0);
        step();
        chk("flush_cnt", {32'h0, wb_retire_cnt}, 64'd16);

        // Asynchronous reset while a bundle is held by a stall.
        wb_wr = 1'b1;
        step();
        wb_wr = 1'b0; wb_diswr = 1'b1;
        step();
        chk("hold_valid", {62'h0, wb_valid}, 64'h3);
        #2 resetn = 1'b0;
        #1;
        chk("areset_valid", {62'h0, wb_valid}, 64'h0);
        chk("areset_we", {62'h0, wb_we}, 64'h0);
        chk("areset_result", wb_result, 64'h0);
        chk("areset_cnt", {32'h0, wb_retire_cnt}, 64'h0);
        #1 resetn = 1'b1;
        wb_diswr = 1'b0;
        step();
        chk("post_reset_cnt", {32'h0, wb_retire_cnt}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
